// File: rtl/uart_regs_fifo.sv
// UART register block: TX push strobe, RX FIFO with level/overflow tracking,
// byte-strobed CONFIG and INT_EN registers, sticky W1C error flags and a
// registered interrupt output built from five maskable sources.
module uart_regs_fifo #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RX_FIFO_DEPTH = 8,
    parameter int BAUD_WIDTH    = 13
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] ip_addr,
    input  logic [DATA_WIDTH-1:0] ip_write_data,
    input  logic [3:0]            ip_byte_strobe,
    input  logic                  valid_reg_write,
    input  logic                  valid_reg_read,
    output logic [DATA_WIDTH-1:0] ip_read_data,
    output logic                  ip_read_data_valid,
    output logic                  tx_data_reg_wr,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_valid,
    input  logic                  rx_parity_err,
    output logic [BAUD_WIDTH-1:0] baud_val,
    output logic                  data_bits,
    output logic                  parity_en,
    output logic                  parity_odd0_even1,
    output logic                  irq
);

    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] OFF_TX     = 3'd0;
    localparam logic [2:0] OFF_RX     = 3'd1;
    localparam logic [2:0] OFF_CONFIG = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_INT_EN = 3'd4;

    logic [2:0]       sel;
    logic [7:0]       rx_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] rx_level;
    logic [7:0]       level_ext;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_clr;
    logic             push_ok;
    logic             ovf_set;
    logic             par_set;
    logic             status_w1c;
    logic             overflow;
    logic             parity_err;
    logic [4:0]       int_en;
    logic [7:0]       rx_thresh;
    logic             thresh_hit;
    logic [15:0]      baud_ext;
    logic [15:0]      baud_new;
    logic [DATA_WIDTH-1:0] rd_data_p0;
    logic             unused_ok;

    assign sel      = ip_addr[4:2];
    assign tx_data  = ip_write_data[7:0];
    assign tx_data_reg_wr = valid_reg_write && (sel == OFF_TX) && ip_byte_strobe[0];

    assign fifo_empty = (rx_level == '0);
    assign fifo_full  = (rx_level == LVL_W'(RX_FIFO_DEPTH));
    assign fifo_pop   = valid_reg_read && (sel == OFF_RX) && !fifo_empty;
    assign fifo_clr   = valid_reg_write && (sel == OFF_CONFIG) && ip_byte_strobe[2] && ip_write_data[19];
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok    = rx_data_valid && !fifo_clr && (!fifo_full || fifo_pop);
    assign ovf_set    = rx_data_valid && !fifo_clr && fifo_full && !fifo_pop;
    assign par_set    = rx_data_valid && rx_parity_err;
    assign status_w1c = valid_reg_write && (sel == OFF_STATUS) && ip_byte_strobe[0];
    assign thresh_hit = (rx_thresh != 8'd0) && (level_ext >= rx_thresh);

    assign unused_ok  = ^{ip_addr, ip_write_data, baud_new};

    // Zero-extend narrow state into register-map fields and merge strobed baud lanes.
    always_comb begin
        level_ext = '0;
        level_ext[LVL_W-1:0] = rx_level;
        baud_ext = '0;
        baud_ext[BAUD_WIDTH-1:0] = baud_val;
        baud_new = baud_ext;
        if (ip_byte_strobe[0]) baud_new[7:0]  = ip_write_data[7:0];
        if (ip_byte_strobe[1]) baud_new[15:8] = ip_write_data[15:8];
    end

    // Read mux: value returned for the register selected this cycle.
    always_comb begin
        rd_data_p0 = '0;
        case (sel)
            OFF_RX: begin
                if (fifo_empty) rd_data_p0[31] = 1'b1;
                else            rd_data_p0[7:0] = rx_mem[rd_ptr];
            end
            OFF_CONFIG: begin
                rd_data_p0[15:0] = baud_ext;
                rd_data_p0[16]   = data_bits;
                rd_data_p0[17]   = parity_en;
                rd_data_p0[18]   = parity_odd0_even1;
            end
            OFF_STATUS: begin
                rd_data_p0[0]    = tx_ready;
                rd_data_p0[1]    = !fifo_empty;
                rd_data_p0[2]    = fifo_full;
                rd_data_p0[3]    = overflow;
                rd_data_p0[4]    = parity_err;
                rd_data_p0[15:8] = level_ext;
            end
            OFF_INT_EN: begin
                rd_data_p0[4:0]  = int_en;
                rd_data_p0[15:8] = rx_thresh;
            end
            default: rd_data_p0 = '0;
        endcase
    end

    // FIFO storage: payload only, never reset.
    always_ff @(posedge ACLK) begin
        if (push_ok) rx_mem[wr_ptr] <= rx_data;
    end

    // FIFO pointers and fill level; clear overrides any push or pop.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
        end else if (fifo_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
        end else begin
            if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, fifo_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    // Sticky error flags: a new event beats a simultaneous write-1-to-clear.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overflow   <= ovf_set || (overflow   && !(status_w1c && ip_write_data[3]));
            parity_err <= par_set || (parity_err && !(status_w1c && ip_write_data[4]));
        end
    end

    // CONFIG register, written lane by lane.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            baud_val          <= '0;
            data_bits         <= 1'b0;
            parity_en         <= 1'b0;
            parity_odd0_even1 <= 1'b0;
        end else if (valid_reg_write && (sel == OFF_CONFIG)) begin
            baud_val <= baud_new[BAUD_WIDTH-1:0];
            if (ip_byte_strobe[2]) begin
                data_bits         <= ip_write_data[16];
                parity_en         <= ip_write_data[17];
                parity_odd0_even1 <= ip_write_data[18];
            end
        end
    end

    // INT_EN register: source enables in lane 0, threshold in lane 1.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            int_en    <= '0;
            rx_thresh <= '0;
        end else if (valid_reg_write && (sel == OFF_INT_EN)) begin
            if (ip_byte_strobe[0]) int_en    <= ip_write_data[4:0];
            if (ip_byte_strobe[1]) rx_thresh <= ip_write_data[15:8];
        end
    end

    // Registered read port; data is forced to zero when no read was issued.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ip_read_data       <= '0;
            ip_read_data_valid <= 1'b0;
        end else begin
            ip_read_data       <= valid_reg_read ? rd_data_p0 : '0;
            ip_read_data_valid <= valid_reg_read;
        end
    end

    // Interrupt: OR of enabled conditions, one cycle behind them.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            irq <= 1'b0;
        end else begin
            irq <= (int_en[0] && tx_ready)    ||
                   (int_en[1] && !fifo_empty) ||
                   (int_en[2] && thresh_hit)  ||
                   (int_en[3] && overflow)    ||
                   (int_en[4] && parity_err);
        end
    end

endmodule

// File: tb/tb_uart_regs_fifo.sv
// Randomised bench for uart_regs_fifo against a queue-based register model.
module tb_uart_regs_fifo;

    localparam int DEPTH  = 8;
    localparam int BAUD_W = 13;
    localparam logic [15:0] BAUD_MASK = 16'h1FFF;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] ip_addr;
    logic [31:0] ip_write_data;
    logic [3:0]  ip_byte_strobe;
    logic        valid_reg_write;
    logic        valid_reg_read;
    logic [31:0] ip_read_data;
    logic        ip_read_data_valid;
    logic        tx_data_reg_wr;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_parity_err;
    logic [BAUD_W-1:0] baud_val;
    logic        data_bits;
    logic        parity_en;
    logic        parity_odd0_even1;
    logic        irq;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state
    byte unsigned mq[$];
    logic [15:0]  m_baud;
    logic         m_db, m_pe, m_po, m_ovf, m_par;
    logic [4:0]   m_ien;
    logic [7:0]   m_thr;

    uart_regs_fifo #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RX_FIFO_DEPTH(DEPTH), .BAUD_WIDTH(BAUD_W)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ip_addr(ip_addr), .ip_write_data(ip_write_data), .ip_byte_strobe(ip_byte_strobe),
        .valid_reg_write(valid_reg_write), .valid_reg_read(valid_reg_read),
        .ip_read_data(ip_read_data), .ip_read_data_valid(ip_read_data_valid),
        .tx_data_reg_wr(tx_data_reg_wr), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_parity_err(rx_parity_err),
        .baud_val(baud_val), .data_bits(data_bits), .parity_en(parity_en),
        .parity_odd0_even1(parity_odd0_even1), .irq(irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_baud = '0; m_db = 0; m_pe = 0; m_po = 0; m_ovf = 0; m_par = 0;
        m_ien = '0; m_thr = '0;
    endfunction

    function automatic logic [31:0] m_config();
        return {13'h0, m_po, m_pe, m_db, m_baud};
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(mq.size()), 3'b0, m_par, m_ovf, (mq.size() == DEPTH), (mq.size() != 0), tx_ready};
    endfunction

    function automatic logic [31:0] m_int_en();
        return {16'h0, m_thr, 3'b0, m_ien};
    endfunction

    function automatic logic m_irq();
        int n = mq.size();
        return (m_ien[0] && tx_ready) || (m_ien[1] && n > 0) ||
               (m_ien[2] && m_thr != 0 && n >= int'(m_thr)) ||
               (m_ien[3] && m_ovf) || (m_ien[4] && m_par);
    endfunction

    function automatic logic [31:0] m_read(input int off);
        case (off)
            1: return (mq.size() > 0) ? {24'h0, mq[0]} : 32'h8000_0000;
            2: return m_config();
            3: return m_status();
            4: return m_int_en();
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive an optional access and an optional RX push, then
    // compare every output against the model. Entered just after a rising edge.
    task automatic step(input bit wr, input bit rd, input int off, input logic [31:0] d,
                        input logic [3:0] s, input bit push, input logic [7:0] pb, input bit perr);
        logic [31:0] addr, exp_rd, c;
        logic        exp_irq;
        bit          pop, clr, ovf_set;
        addr = $urandom;
        addr[4:2] = 3'(off);
        ip_addr = addr; ip_write_data = d; ip_byte_strobe = s;
        valid_reg_write = wr; valid_reg_read = rd;
        rx_data_valid = push; rx_data = pb; rx_parity_err = perr;
        exp_rd  = rd ? m_read(off) : 32'h0;
        exp_irq = m_irq();
        #1;
        check("tx_wr", {31'h0, tx_data_reg_wr}, {31'h0, (wr && off == 0 && s[0])});
        check("tx_data", {24'h0, tx_data}, {24'h0, d[7:0]});
        @(posedge ACLK);
        #1;
        valid_reg_write = 0; valid_reg_read = 0; rx_data_valid = 0; rx_parity_err = 0;
        // Model update
        pop = rd && off == 1 && mq.size() > 0;
        clr = wr && off == 2 && s[2] && d[19];
        ovf_set = 0;
        if (clr) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(pb);
                else ovf_set = 1;
            end
        end
        if (wr && off == 3 && s[0]) begin
            if (d[3]) m_ovf = 0;
            if (d[4]) m_par = 0;
        end
        if (ovf_set) m_ovf = 1;
        if (push && perr) m_par = 1;
        if (wr && off == 2) begin
            c = m_config();
            for (int k = 0; k < 3; k++) if (s[k]) c[8*k +: 8] = d[8*k +: 8];
            m_baud = c[15:0] & BAUD_MASK;
            m_db = c[16]; m_pe = c[17]; m_po = c[18];
        end
        if (wr && off == 4) begin
            if (s[0]) m_ien = d[4:0];
            if (s[1]) m_thr = d[15:8];
        end
        check("rdata", ip_read_data, exp_rd);
        check("rvalid", {31'h0, ip_read_data_valid}, {31'h0, rd});
        check("irq", {31'h0, irq}, {31'h0, exp_irq});
        check("baud", {19'h0, baud_val}, {16'h0, m_baud});
        check("flags", {29'h0, parity_odd0_even1, parity_en, data_bits}, {29'h0, m_po, m_pe, m_db});
    endtask

    task automatic reg_wr(input int off, input logic [31:0] d, input logic [3:0] s);
        step(1, 0, off, d, s, 0, 8'h0, 0);
    endtask
    task automatic reg_rd(input int off);
        step(0, 1, off, 32'h0, 4'h0, 0, 8'h0, 0);
    endtask
    task automatic push(input logic [7:0] b);
        step(0, 0, 0, 32'h0, 4'h0, 1, b, 0);
    endtask
    task automatic idle();
        step(0, 0, 0, 32'h0, 4'h0, 0, 8'h0, 0);
    endtask

    initial begin
        ARESETn = 0; ip_addr = 0; ip_write_data = 0; ip_byte_strobe = 0;
        valid_reg_write = 0; valid_reg_read = 0; tx_ready = 1;
        rx_data = 0; rx_data_valid = 0; rx_parity_err = 0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1;
        phase = "reset";
        check("rdata", ip_read_data, 32'h0);
        check("rvalid", {31'h0, ip_read_data_valid}, 32'h0);
        check("irq", {31'h0, irq}, 32'h0);
        check("baud", {19'h0, baud_val}, 32'h0);
        check("flags", {29'h0, parity_odd0_even1, parity_en, data_bits}, 32'h0);
        ARESETn = 1;
        for (int i = 0; i < 8; i++) reg_rd(i);

        phase = "config";
        reg_wr(2, 32'h0007_1234, 4'hF);
        check("cfg_baud", {19'h0, baud_val}, 32'h0000_1234);
        reg_rd(2);
        check("cfg_rb", ip_read_data, 32'h0007_1234);

        phase = "strobe";
        reg_wr(2, 32'hFFFF_FFFF, 4'h1);
        reg_rd(2);
        check("strobe_rb", ip_read_data, 32'h0007_12FF);

        phase = "fill";
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        reg_rd(3);
        check("full_status", ip_read_data & 32'h0000_FF04, 32'h0000_0804);
        for (int i = 0; i < 9; i++) reg_rd(1);
        check("empty_read", ip_read_data, 32'h8000_0000);

        phase = "overflow";
        for (int i = 0; i < 8; i++) push(8'($urandom));
        push(8'hAA);
        reg_rd(3);
        check("ovf_set", ip_read_data & 32'h0000_FF0C, 32'h0000_080C);
        reg_wr(3, 32'h8, 4'h1);
        step(0, 1, 1, 32'h0, 4'h0, 1, 8'h55, 0);
        reg_rd(3);
        check("pushpop_full", ip_read_data & 32'h0000_FF0C, 32'h0000_0804);

        phase = "set_vs_clr";
        step(1, 0, 3, 32'h10, 4'h1, 1, 8'h66, 1);
        reg_rd(3);
        check("par_sticky", ip_read_data & 32'h10, 32'h10);

        phase = "irq";
        reg_wr(2, 32'h0008_0000, 4'h4);
        reg_wr(3, 32'h18, 4'h1);
        reg_wr(4, 32'h0000_0304, 4'h3);
        push(8'h01); push(8'h02); push(8'h03);
        check("irq_lag", {31'h0, irq}, 32'h0);
        idle();
        check("irq_rise", {31'h0, irq}, 32'h1);
        reg_rd(1);
        idle();
        check("irq_fall", {31'h0, irq}, 32'h0);
        step(1, 0, 2, 32'h0008_0000, 4'h4, 1, 8'h77, 0);
        reg_rd(3);
        check("clr_push", ip_read_data & 32'h0000_FF0E, 32'h0);

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 9);
            bit wr = (r < 2);
            bit rd = (r >= 2 && r < 5);
            int off = (rd && $urandom_range(0, 2) != 0) ? 1 : $urandom_range(0, 7);
            logic [31:0] d = $urandom;
            if (wr && off == 2 && $urandom_range(0, 3) != 0) d[19] = 1'b0;
            if (wr && off == 4) d[15:8] = 8'($urandom_range(0, 9));
            tx_ready = 1'($urandom);
            step(wr, rd, off, d, 4'($urandom), ($urandom_range(0, 9) < 5), 8'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        phase = "async_rst";
        tx_ready = 1;
        reg_wr(4, 32'h1, 4'h1);
        push(8'hC3); push(8'h3C);
        idle();
        check("irq_before", {31'h0, irq}, 32'h1);
        #3;
        ARESETn = 0;
        #1;
        check("irq_drop", {31'h0, irq}, 32'h0);
        check("baud_drop", {19'h0, baud_val}, 32'h0);
        model_reset();
        @(posedge ACLK);
        #1;
        ARESETn = 1;
        reg_rd(3);
        check("lvl_after", ip_read_data, 32'h1);
        reg_rd(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
